// File: rtl/truth_table_sweeper_pkg.sv
// Shared constants and FSM state type for the truth-table sweeper.
package truth_table_sweeper_pkg;

  localparam int unsigned VECTOR_COUNT = 16;
  localparam int unsigned IDX_W        = 4;
  localparam int unsigned CNT_W        = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/truth_table_sweeper_settle_counter.sv
// Counts the settle cycles for the current vector; clr takes priority over en.
module settle_counter
  import truth_table_sweeper_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic term_c
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign term_c = (cnt == CNT_W'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps all 16 input vectors of an external 4-input circuit, captures its
// responses into tables and compares them against latched expected tables.
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [VECTOR_COUNT-1:0] exp_o1,
  input  logic [VECTOR_COUNT-1:0] exp_o2,
  output logic                    dut_a,
  output logic                    dut_b,
  output logic                    dut_c,
  output logic                    dut_d,
  input  logic                    dut_o1,
  input  logic                    dut_o2,
  input  logic                    dut_p,
  output logic                    busy,
  output logic                    done,
  output logic [VECTOR_COUNT-1:0] o1_table,
  output logic [VECTOR_COUNT-1:0] o2_table,
  output logic                    pass,
  output logic                    p_fault
);

  state_t                  state, state_n;
  logic [IDX_W-1:0]        idx, idx_n;
  logic                    cnt_clr, cnt_en, cnt_term;
  logic                    accept;
  logic [VECTOR_COUNT-1:0] exp1_q, exp2_q;
  logic [VECTOR_COUNT-1:0] o1_n, o2_n;
  logic                    p_fault_n;
  logic [IDX_W-1:0]        vec_q;

  settle_counter #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_settle_counter (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .term_c (cnt_term)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  // Next state, counter control and the table contents after this capture.
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    accept    = 1'b0;
    o1_n      = o1_table;
    o2_n      = o2_table;
    p_fault_n = p_fault;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_n = ST_SETTLE;
          idx_n   = '0;
          cnt_clr = 1'b1;
        end
      end
      ST_SETTLE: begin
        cnt_en = 1'b1;
        if (cnt_term) state_n = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        cnt_clr      = 1'b1;
        o1_n[idx]    = dut_o1;
        o2_n[idx]    = dut_o2;
        p_fault_n    = p_fault | dut_p;
        if (idx == IDX_W'(VECTOR_COUNT - 1)) begin
          state_n = ST_DONE;
        end else begin
          idx_n   = idx + IDX_W'(1);
          state_n = ST_SETTLE;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Registered outputs, computed from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      vec_q    <= '0;
      exp1_q   <= '0;
      exp2_q   <= '0;
      o1_table <= '0;
      o2_table <= '0;
      p_fault  <= 1'b0;
      pass     <= 1'b0;
    end else begin
      busy  <= (state_n == ST_SETTLE) || (state_n == ST_CAPTURE);
      done  <= (state_n == ST_DONE);
      vec_q <= ((state_n == ST_SETTLE) || (state_n == ST_CAPTURE)) ? idx_n : '0;
      if (accept) begin
        exp1_q   <= exp_o1;
        exp2_q   <= exp_o2;
        o1_table <= '0;
        o2_table <= '0;
        p_fault  <= 1'b0;
        pass     <= 1'b0;
      end
      if (state == ST_CAPTURE) begin
        o1_table <= o1_n;
        o2_table <= o2_n;
        p_fault  <= p_fault_n;
      end
      if ((state == ST_CAPTURE) && (state_n == ST_DONE)) begin
        pass <= (o1_n == exp1_q) && (o2_n == exp2_q) && !p_fault_n;
      end
    end
  end

  assign {dut_a, dut_b, dut_c, dut_d} = vec_q;

endmodule

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, meaning cycles each input vector is held before sampling (legal range 1..15).
REQ-002 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request one full sweep; sampled only in IDLE.
REQ-005 SHALL have port exp_o1  input  16  expected O1 table; bit i is the response to vector i.
REQ-006 SHALL have port exp_o2  input  16  expected O2 table.
REQ-007 SHALL have ports dut_a, dut_b, dut_c, dut_d  output  1 each  drive the four inputs of the combinational circuit under test.
REQ-008 SHALL have ports dut_o1, dut_o2, dut_p  input  1 each  responses of the circuit under test.
REQ-009 SHALL have port busy  output  1  high from the cycle after start is accepted until done.
REQ-010 SHALL have port done  output  1  one-cycle pulse at sweep end.
REQ-011 SHALL have port o1_table, o2_table  output  16 each  captured responses.
REQ-012 SHALL have port pass  output  1  comparison result, valid from done until the next start.
REQ-013 SHALL have port p_fault  output  1  sticky; set if dut_p was 1 at any capture of the current sweep.

Function
REQ-014 SHALL implement states IDLE, SETTLE, CAPTURE, DONE.
REQ-015 IDLE with start=1 SHALL go to SETTLE, set idx=0 and cnt=0, latch exp_o1/exp_o2, and clear both tables and p_fault.
REQ-016 SHALL drive {dut_a,dut_b,dut_c,dut_d} = idx (dut_a MSB) in SETTLE and CAPTURE, and 4'b0000 in IDLE and DONE.
REQ-017 SETTLE SHALL increment cnt each cycle and go to CAPTURE when cnt == SETTLE_CYCLES-1.
REQ-018 CAPTURE SHALL write dut_o1 to o1_table[idx] and dut_o2 to o2_table[idx], and OR dut_p into p_fault.
REQ-019 After a CAPTURE with idx < 15, the FSM SHALL increment idx, clear cnt and return to SETTLE.
REQ-020 After a CAPTURE with idx == 15, the FSM SHALL go to DONE; idx SHALL NOT wrap.
REQ-021 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-022 Each vector SHALL take SETTLE_CYCLES+1 cycles.
REQ-023 done SHALL be high in the cycle that starts 16*(SETTLE_CYCLES+1) clock edges after the edge that accepted start.
REQ-024 pass SHALL equal (o1_table==latched exp_o1) AND (o2_table==latched exp_o2) AND NOT p_fault; it is registered in DONE and held through IDLE.
REQ-025 start SHALL be ignored while busy or in DONE; changes on exp_o1/exp_o2 during a sweep SHALL have no effect.
REQ-026 start held high continuously SHALL begin a new sweep on the first IDLE cycle after DONE.
REQ-027 o1_table, o2_table, pass and p_fault SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-028 rst=1 SHALL, at the next edge and regardless of state (including mid-sweep), force IDLE, idx=0, cnt=0 and clear all captured state.
REQ-029 After reset, every output SHALL be 0: busy, done, pass, p_fault, o1_table, o2_table and the dut_* drives.
REQ-030 rst SHALL take priority over a simultaneous start.

Structure
REQ-031 A shared package SHALL hold the state enumeration, the VECTOR_COUNT=16 constant and the index width constant (4).
REQ-032 One sub-module, settle_counter, SHALL hold cnt and provide a terminal-count flag, with clear/enable inputs from the FSM.
REQ-033 The circuit under test SHALL be external to this block, connected only through the dut_* ports.

Verification
REQ-034 Bench model O1=A&B, O2=D, p=0, SETTLE_CYCLES=2, exp_o1=16'hF000, exp_o2=16'hAAAA, start pulse -> done at edge 48; o1_table=16'hF000; o2_table=16'hAAAA; pass=1; busy high for 48 cycles.
REQ-035 Same model with exp_o2=16'hAAAB -> pass=0, p_fault=0, tables unchanged.
REQ-036 Model driving p=1 only on vector 7 -> p_fault=1, pass=0.
REQ-037 rst asserted at edge 20 of a sweep -> next cycle IDLE with all outputs 0; a following start gives a correct full sweep.
REQ-038 start re-pulsed at edges 5 and 30 of a sweep -> ignored, exactly one done.
REQ-039 SETTLE_CYCLES=1 and =15 -> done at edges 32 and 256; dut_* inputs stable for every vector's full hold window.
